mux4x1_rr: RTL and testbench
============================

MUX4X1_RR -- requirements
Module: mux4x1_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data width of every channel and of the output.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising clk edge.
REQ-004 SHALL have ports D0, D1, D2, D3, input, WIDTH each: channel data.
REQ-005 SHALL have ports V0, V1, V2, V3, input, 1 each: channel data valid.
REQ-006 SHALL have ports R0, R1, R2, R3, output, 1 each: channel ready, combinational.
REQ-007 SHALL have port Y, output, WIDTH: registered output data.
REQ-008 SHALL have port YV, output, 1: output valid, registered.
REQ-009 SHALL have port YR, input, 1: downstream ready.
REQ-010 SHALL have ports S1 and S0, output, 1 each: registered source-channel index of Y, with S1 as the MSB. This lets a downstream 1x4 demux route the data back by channel.
REQ-011 SHALL have port CNT, output, 8 bits: registered count of completed output transfers.

Function
REQ-012 A channel transfer SHALL occur on an edge where Vi=1 and Ri=1. An output transfer SHALL occur on an edge where YV=1 and YR=1.
REQ-013 The output register SHALL be loadable in a cycle when YV=0 or YR=1 (load_ok).
REQ-014 In a load_ok cycle with at least one Vi=1, exactly one channel SHALL be granted, using round-robin priority starting at last_grant+1 mod 4.
REQ-015 Ri SHALL be 1 only for the granted channel in a load_ok cycle, and 0 for all other channels.
  - Ri SHALL NOT depend on Di.
REQ-016 On a channel transfer from channel i, the following SHALL be registered on the next edge:
  - Y <= Di
  - {S1,S0} <= i
  - YV <= 1
  - last_grant <= i
  - Latency from channel transfer to Y visible SHALL be 1 cycle.
REQ-017 In a load_ok cycle with no Vi=1, YV SHALL clear to 0 on the next edge, and Y, S1, S0 and last_grant SHALL hold.
REQ-018 When YV=1 and YR=0, Y, YV, S1 and S0 SHALL hold, and all Ri SHALL be 0 (back-pressure).
REQ-019 Simultaneous output transfer and new channel transfer in the same cycle SHALL be supported, giving one word per cycle sustained throughput.
REQ-020 Fairness: with all four Vi held at 1 and YR=1, grants SHALL rotate 0,1,2,3,0,... one per cycle.
REQ-021 Fairness: a continuously requesting channel SHALL be granted within 4 load_ok cycles.
REQ-022 CNT SHALL increment by 1 on every output transfer, wrapping from 255 to 0.
REQ-023 CNT SHALL hold when no output transfer occurs.
REQ-024 Y SHALL be don't-care when YV=0. The bench SHALL check Y, S1 and S0 only when YV=1.

Reset
REQ-025 On an edge with rst_n=0, the block SHALL set YV=0, Y=0, S1=0, S0=0, CNT=0 and last_grant=3, so channel 0 has top priority after reset.
REQ-026 While rst_n=0, all Ri SHALL be 0.
REQ-027 Reset asserted mid-transfer SHALL discard any held output word. No channel transfer SHALL be counted in that cycle.
REQ-028 The first grant is permitted on the first edge after rst_n returns to 1.

Verification
REQ-029 Scenario, single channel: after reset, V2=1, D2=8'hA5, YR=1 for one cycle -> R2=1 that cycle; next cycle Y=8'hA5, YV=1, S1=1, S0=0; CNT=1 one cycle later.
REQ-030 Scenario, round robin: V0..V3=1, D0..D3=8'h10,8'h11,8'h12,8'h13, YR=1 for 8 cycles -> Y sequence 10,11,12,13,10,11,12,13 on consecutive cycles; {S1,S0} sequence 0,1,2,3,...
REQ-031 Scenario, back-pressure: Y=8'h3C held with YV=1, YR=0 for 5 cycles while V1=1 -> Y, S1, S0 stable; R0..R3=0 throughout; CNT unchanged. With YR=1, the output transfer completes and channel 1 is loaded on the same edge.
REQ-032 Scenario, CNT wrap: 256 output transfers from reset -> CNT returns to 0.
REQ-033 Scenario, reset mid-stream: rst_n=0 for one cycle while YV=1 and YR=0 -> YV=0, CNT=0, all Ri=0. If V0 and V3 are both 1 afterwards, channel 0 is granted first.
REQ-034 Scenario, idle: all Vi=0, YR=1 -> YV=0 from the edge after the last output transfer; CNT holds.

Source files
------------

// File: rtl/mux4x1_rr.sv
// mux4x1_rr: four-channel valid/ready round-robin mux into a registered output stage with transfer count
module mux4x1_rr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  input  logic             V0,
  input  logic             V1,
  input  logic             V2,
  input  logic             V3,
  output logic             R0,
  output logic             R1,
  output logic             R2,
  output logic             R3,
  output logic [WIDTH-1:0] Y,
  output logic             YV,
  input  logic             YR,
  output logic             S1,
  output logic             S0,
  output logic [7:0]       CNT
);
  logic [WIDTH-1:0] d [4];
  logic [3:0] v, r;
  logic [1:0] last_grant, gnt;
  logic gnt_ok, load_ok;
  assign d = '{D0, D1, D2, D3};
  assign v = {V3, V2, V1, V0};
  assign load_ok = rst_n & (~YV | YR);
  // descending scan so the nearest channel after last_grant wins
  always_comb begin
    gnt_ok = 1'b0;
    gnt = last_grant;
    for (int k = 4; k >= 1; k--)
      if (v[last_grant + 2'(k)]) begin
        gnt_ok = 1'b1;
        gnt = last_grant + 2'(k);
      end
  end
  assign r = {4{load_ok & gnt_ok}} & (4'b0001 << gnt);
  assign {R3, R2, R1, R0} = r;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Y <= '0;
      YV <= 1'b0;
      {S1, S0} <= 2'd0;
      CNT <= 8'd0;
      last_grant <= 2'd3;
    end else begin
      if (YV && YR) CNT <= CNT + 8'd1;
      if (load_ok) begin
        YV <= gnt_ok;
        if (gnt_ok) begin
          Y <= d[gnt];
          {S1, S0} <= gnt;
          last_grant <= gnt;
        end
      end
    end
  end
endmodule

// File: tb/tb_mux4x1_rr.sv
// tb_mux4x1_rr: randomized and directed checks of mux4x1_rr against a transaction-level model
module tb_mux4x1_rr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] d [4];
  logic [3:0] v = 4'd0;
  logic yr = 1'b0;
  logic R0, R1, R2, R3, YV, S1, S0;
  logic [7:0] Y, CNT;
  int n = 0;
  int errs = 0;
  bit m_yv;
  logic [7:0] m_y;
  int m_s, m_cnt, m_last;
  mux4x1_rr #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .V0(v[0]), .V1(v[1]), .V2(v[2]), .V3(v[3]),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3),
    .Y(Y), .YV(YV), .YR(yr), .S1(S1), .S0(S0), .CNT(CNT)
  );
  always #5 clk = ~clk;
  function automatic int grant();
    for (int k = 1; k <= 4; k++) if (v[(m_last + k) % 4]) return (m_last + k) % 4;
    return -1;
  endfunction
  function automatic logic [3:0] exp_r();
    if (!rst_n || (m_yv && !yr) || grant() < 0) return 4'd0;
    return 4'(1 << grant());
  endfunction
  task automatic tick();
    int g;
    g = grant();
    if (!rst_n) begin
      m_yv = 0; m_y = 0; m_s = 0; m_cnt = 0; m_last = 3;
    end else begin
      if (m_yv && yr) m_cnt = (m_cnt + 1) % 256;
      if (!m_yv || yr) begin
        m_yv = (g >= 0);
        if (g >= 0) begin m_y = d[g]; m_s = g; m_last = g; end
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0; tick(); rst_n = 1;
  endtask
  task automatic test_reset();
    v = 4'hF; yr = 1; rst_n = 0;
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    #1;
    n++; if ({R3, R2, R1, R0} !== 4'd0) begin errs++; $display("FAIL reset_r got %b exp 0000", {R3, R2, R1, R0}); end
    tick(); tick();
    n++; if (YV !== 1'b0) begin errs++; $display("FAIL reset_yv got %b exp 0", YV); end
    n++; if (Y !== 8'd0 || {S1, S0} !== 2'd0) begin errs++; $display("FAIL reset_y_s got %h/%0d exp 00/0", Y, {S1, S0}); end
    n++; if (CNT !== 8'd0) begin errs++; $display("FAIL reset_cnt got %0d exp 0", CNT); end
    v = 0; rst_n = 1; #1;
  endtask
  task automatic test_single();
    do_reset();
    v = 4'b0100; d[2] = 8'hA5; yr = 1; #1;
    n++; if ({R3, R2, R1, R0} !== 4'b0100) begin errs++; $display("FAIL single_r got %b exp 0100", {R3, R2, R1, R0}); end
    tick(); v = 0;
    n++; if (Y !== 8'hA5 || YV !== 1'b1 || {S1, S0} !== 2'd2) begin errs++; $display("FAIL single_out got y=%h yv=%b s=%0d exp a5/1/2", Y, YV, {S1, S0}); end
    n++; if (CNT !== 8'd0) begin errs++; $display("FAIL single_cnt0 got %0d exp 0", CNT); end
    tick();
    n++; if (CNT !== 8'd1 || YV !== 1'b0) begin errs++; $display("FAIL single_cnt1 got cnt=%0d yv=%b exp 1/0", CNT, YV); end
  endtask
  task automatic test_round_robin();
    do_reset();
    v = 4'hF; yr = 1;
    for (int i = 0; i < 4; i++) d[i] = 8'h10 + 8'(i);
    #1;
    for (int i = 0; i < 8; i++) begin
      n++; if ({R3, R2, R1, R0} !== 4'(1 << (i % 4))) begin errs++; $display("FAIL rr_r%0d got %b exp %b", i, {R3, R2, R1, R0}, 4'(1 << (i % 4))); end
      tick();
      n++; if (Y !== 8'h10 + 8'(i % 4) || {S1, S0} !== 2'(i % 4) || YV !== 1'b1) begin errs++; $display("FAIL rr_y%0d got %h/%0d exp %h/%0d", i, Y, {S1, S0}, 8'h10 + 8'(i % 4), i % 4); end
    end
    v = 0;
  endtask
  task automatic test_back_pressure();
    logic [7:0] c0;
    do_reset();
    v = 4'b0001; d[0] = 8'h3C; yr = 0; tick();
    c0 = CNT;
    v = 4'b0010; d[1] = 8'($urandom);
    for (int i = 0; i < 5; i++) begin
      #1;
      n++; if ({R3, R2, R1, R0} !== 4'd0) begin errs++; $display("FAIL bp_r%0d got %b exp 0000", i, {R3, R2, R1, R0}); end
      n++; if (Y !== 8'h3C || YV !== 1'b1 || {S1, S0} !== 2'd0 || CNT !== c0) begin errs++; $display("FAIL bp_hold%0d got %h/%b/%0d/%0d exp 3c/1/0/%0d", i, Y, YV, {S1, S0}, CNT, c0); end
      tick();
    end
    yr = 1; #1;
    n++; if ({R3, R2, R1, R0} !== 4'b0010) begin errs++; $display("FAIL bp_release_r got %b exp 0010", {R3, R2, R1, R0}); end
    tick();
    n++; if (Y !== d[1] || {S1, S0} !== 2'd1 || CNT !== c0 + 8'd1) begin errs++; $display("FAIL bp_release got %h/%0d/%0d exp %h/1/%0d", Y, {S1, S0}, CNT, d[1], c0 + 8'd1); end
    v = 0;
  endtask
  task automatic test_cnt_wrap();
    int xfers = 0;
    do_reset();
    v = 4'hF; yr = 1;
    while (xfers < 256) begin
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      if (YV && yr) xfers++;
      tick();
      if (xfers == 255) begin
        n++; if (CNT !== 8'd255) begin errs++; $display("FAIL wrap_255 got %0d exp 255", CNT); end
      end
    end
    n++; if (CNT !== 8'd0) begin errs++; $display("FAIL wrap_0 got %0d exp 0", CNT); end
    v = 0;
  endtask
  task automatic test_reset_mid();
    v = 4'b1000; d[3] = 8'($urandom); yr = 0; tick();
    n++; if (YV !== 1'b1) begin errs++; $display("FAIL mid_setup got yv=%b exp 1", YV); end
    rst_n = 0; v = 4'hF; #1;
    n++; if ({R3, R2, R1, R0} !== 4'd0) begin errs++; $display("FAIL mid_r got %b exp 0000", {R3, R2, R1, R0}); end
    tick(); rst_n = 1;
    n++; if (YV !== 1'b0 || CNT !== 8'd0) begin errs++; $display("FAIL mid_clear got yv=%b cnt=%0d exp 0/0", YV, CNT); end
    v = 4'b1001; yr = 1; #1;
    n++; if ({R3, R2, R1, R0} !== 4'b0001) begin errs++; $display("FAIL mid_first got %b exp 0001", {R3, R2, R1, R0}); end
    tick(); v = 0;
  endtask
  task automatic test_idle();
    logic [7:0] c0;
    v = 0; yr = 1;
    if (YV) tick();
    c0 = CNT;
    for (int i = 0; i < 3; i++) begin
      n++; if (YV !== 1'b0 || CNT !== c0) begin errs++; $display("FAIL idle%0d got yv=%b cnt=%0d exp 0/%0d", i, YV, CNT, c0); end
      tick();
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      v = 4'($urandom);
      yr = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
      #1;
      n++; if ({R3, R2, R1, R0} !== exp_r()) begin errs++; $display("FAIL rand_r c=%0d got %b exp %b", c, {R3, R2, R1, R0}, exp_r()); end
      n++; if (YV !== m_yv || CNT !== 8'(m_cnt)) begin errs++; $display("FAIL rand_st c=%0d got yv=%b cnt=%0d exp %b/%0d", c, YV, CNT, m_yv, m_cnt); end
      if (m_yv) begin
        n++; if (Y !== m_y || {S1, S0} !== 2'(m_s)) begin errs++; $display("FAIL rand_y c=%0d got %h/%0d exp %h/%0d", c, Y, {S1, S0}, m_y, m_s); end
      end
      tick();
    end
    rst_n = 1;
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_cnt_wrap();
    test_reset_mid();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
